// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: per-port request fields,
// per-port grant and read-response signals.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 11
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_wen;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*32-1:0]         req_wdata;
  logic [NUM_PORTS*4-1:0]          req_wstrb;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [31:0]                     rsp_rdata;

  // Requesters drive the request fields and observe grant and response.
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // The arbiter observes requests and drives grant and response.
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one ideal-memory port among NUM_PORTS requesters. The grant is
// combinational; read data is registered one cycle after the accept.
// Losers are stalled by holding their ready low.
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int ARB_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pri_en,
  input  logic [$clog2(NUM_PORTS)-1:0]   pri_port,
  mem_port_arbiter_if.slave              bus,
  output logic [ADDR_WIDTH-3:0]          mem_addr,
  output logic                           mem_wen,
  output logic [3:0]                     mem_wstrb,
  output logic [31:0]                    mem_wdata,
  output logic                           mem_ren,
  input  logic [31:0]                    mem_rdata,
  output logic [31:0]                    conflict_cnt
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [PW-1:0]         rr_ptr_reg;
  logic [NUM_PORTS-1:0]  rsp_valid_reg;
  logic [31:0]           rsp_rdata_reg;
  logic [31:0]           conflict_cnt_reg;

  logic [PW-1:0]         win_idx;
  logic                  win_found;
  int                    rr_idx;
  logic [NUM_PORTS-1:0]  grant_vec;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_wen;
  logic [3:0]            win_wstrb;
  logic [31:0]           win_wdata;
  logic                  multi_valid;

  // Winner selection: override first, then fixed-priority or round-robin.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    // Out-of-range override ports (non power-of-two NUM_PORTS) are ignored.
    if (pri_en && (int'(pri_port) < NUM_PORTS) && bus.req_valid[pri_port]) begin
      win_idx   = pri_port;
      win_found = 1'b1;
    end else if (ARB_MODE == 0) begin
      // Descending scan so the lowest valid index is the last one written.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (bus.req_valid[i]) begin
          win_idx   = PW'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      // Cyclic search starting at the round-robin pointer.
      for (int k = 0; k < NUM_PORTS; k++) begin
        rr_idx = (int'(rr_ptr_reg) + k) % NUM_PORTS;
        if (!win_found && bus.req_valid[rr_idx]) begin
          win_idx   = PW'(rr_idx);
          win_found = 1'b1;
        end
      end
    end
  end

  // One-hot grant to the winner only.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
    assign grant_vec[gi] = win_found && (win_idx == PW'(gi));
  end

  assign bus.req_ready = grant_vec;

  // Steer the winner's request fields onto the memory port; all zero when idle.
  assign win_addr  = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wen   = bus.req_wen[win_idx];
  assign win_wstrb = bus.req_wstrb[win_idx*4 +: 4];
  assign win_wdata = bus.req_wdata[win_idx*32 +: 32];

  assign mem_addr  = win_found ? win_addr[ADDR_WIDTH-1:2] : '0;
  assign mem_wen   = win_found & win_wen;
  assign mem_ren   = win_found & ~win_wen;
  assign mem_wstrb = mem_wen ? win_wstrb : 4'h0;
  assign mem_wdata = mem_wen ? win_wdata : 32'h0;

  // Two or more set bits: clearing the lowest set bit leaves something.
  assign multi_valid = |(bus.req_valid & (bus.req_valid - 1'b1));

  // Response capture, round-robin pointer update and contention counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg       <= '0;
      rsp_valid_reg    <= '0;
      rsp_rdata_reg    <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      rsp_valid_reg <= '0;
      if (win_found) begin
        rr_ptr_reg <= (int'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + 1'b1;
        if (!win_wen) begin
          rsp_valid_reg <= grant_vec;
          rsp_rdata_reg <= mem_rdata;
        end
      end
      if (multi_valid && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign conflict_cnt  = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority 2-port arbiter and a round-robin 3-port
// arbiter, each in front of a small ideal memory model.
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;

  int total;
  int passed;
  int failed;

  // Fixed-priority, 2 ports.
  logic        a_pri_en;
  logic [0:0]  a_pri_port;
  logic [8:0]  a_mem_addr;
  logic        a_mem_wen;
  logic [3:0]  a_mem_wstrb;
  logic [31:0] a_mem_wdata;
  logic        a_mem_ren;
  logic [31:0] a_mem_rdata;
  logic [31:0] a_conflict_cnt;
  logic [31:0] mem_a [0:511];

  // Round-robin, 3 ports.
  logic        b_pri_en;
  logic [1:0]  b_pri_port;
  logic [8:0]  b_mem_addr;
  logic        b_mem_wen;
  logic [3:0]  b_mem_wstrb;
  logic [31:0] b_mem_wdata;
  logic        b_mem_ren;
  logic [31:0] b_mem_rdata;
  logic [31:0] b_conflict_cnt;
  logic [31:0] mem_b [0:511];

  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(11)) a_if ();
  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(11)) b_if ();

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(11), .ARB_MODE(0)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .pri_en       (a_pri_en),
    .pri_port     (a_pri_port),
    .bus          (a_if),
    .mem_addr     (a_mem_addr),
    .mem_wen      (a_mem_wen),
    .mem_wstrb    (a_mem_wstrb),
    .mem_wdata    (a_mem_wdata),
    .mem_ren      (a_mem_ren),
    .mem_rdata    (a_mem_rdata),
    .conflict_cnt (a_conflict_cnt)
  );

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(11), .ARB_MODE(1)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .pri_en       (b_pri_en),
    .pri_port     (b_pri_port),
    .bus          (b_if),
    .mem_addr     (b_mem_addr),
    .mem_wen      (b_mem_wen),
    .mem_wstrb    (b_mem_wstrb),
    .mem_wdata    (b_mem_wdata),
    .mem_ren      (b_mem_ren),
    .mem_rdata    (b_mem_rdata),
    .conflict_cnt (b_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal memories: byte-strobed write on the edge, combinational read.
  always @(posedge clk) begin
    if (a_mem_wen)
      for (int k = 0; k < 4; k++)
        if (a_mem_wstrb[k]) mem_a[a_mem_addr][k*8 +: 8] <= a_mem_wdata[k*8 +: 8];
  end
  always @(posedge clk) begin
    if (b_mem_wen)
      for (int k = 0; k < 4; k++)
        if (b_mem_wstrb[k]) mem_b[b_mem_addr][k*8 +: 8] <= b_mem_wdata[k*8 +: 8];
  end
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input int p, input logic v, input logic w, input logic [10:0] addr,
                       input logic [31:0] d, input logic [3:0] s);
    a_if.req_valid[p]           = v;
    a_if.req_wen[p]             = w;
    a_if.req_addr[p*11 +: 11]   = addr;
    a_if.req_wdata[p*32 +: 32]  = d;
    a_if.req_wstrb[p*4 +: 4]    = s;
  endtask

  task automatic b_set(input int p, input logic v, input logic w, input logic [10:0] addr,
                       input logic [31:0] d, input logic [3:0] s);
    b_if.req_valid[p]           = v;
    b_if.req_wen[p]             = w;
    b_if.req_addr[p*11 +: 11]   = addr;
    b_if.req_wdata[p*32 +: 32]  = d;
    b_if.req_wstrb[p*4 +: 4]    = s;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst_n  = 1'b0;
    a_pri_en = 1'b0; a_pri_port = '0;
    b_pri_en = 1'b0; b_pri_port = '0;
    a_if.req_valid = '0; a_if.req_wen = '0; a_if.req_addr = '0;
    a_if.req_wdata = '0; a_if.req_wstrb = '0;
    b_if.req_valid = '0; b_if.req_wen = '0; b_if.req_addr = '0;
    b_if.req_wdata = '0; b_if.req_wstrb = '0;

    // Reset state
    tick(); tick();
    check("rst_a_rsp_valid", 32'(a_if.rsp_valid), 32'h0);
    check("rst_a_rsp_rdata", a_if.rsp_rdata, 32'h0);
    check("rst_a_conflict", a_conflict_cnt, 32'h0);
    check("rst_a_ready", 32'(a_if.req_ready), 32'h0);
    check("rst_a_mem_ctl", {30'h0, a_mem_wen, a_mem_ren}, 32'h0);
    check("rst_b_rsp_valid", 32'(b_if.rsp_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single port write then read
    a_set(0, 1'b1, 1'b1, 11'h010, 32'hDEADBEEF, 4'hF);
    #2;
    check("a_wr_ready", 32'(a_if.req_ready), 32'h1);
    check("a_wr_mem_wen", 32'(a_mem_wen), 32'h1);
    check("a_wr_mem_addr", 32'(a_mem_addr), 32'h4);
    check("a_wr_mem_wstrb", 32'(a_mem_wstrb), 32'hF);
    check("a_wr_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    tick();
    check("a_wr_no_rsp", 32'(a_if.rsp_valid), 32'h0);
    a_set(0, 1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
    #2;
    check("a_rd_mem_ren", 32'(a_mem_ren), 32'h1);
    tick();
    check("a_rd_rsp_valid", 32'(a_if.rsp_valid), 32'h1);
    check("a_rd_rdata", a_if.rsp_rdata, 32'hDEADBEEF);
    check("a_rd_conflict", a_conflict_cnt, 32'h0);
    a_set(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    #2;
    check("a_idle_mem", {a_mem_wen, a_mem_ren, 21'h0, a_mem_addr}, 32'h0);
    tick();
    check("a_rsp_pulse_end", 32'(a_if.rsp_valid), 32'h0);

    // Byte strobes, zero-strobe write, ignored low address bits
    a_set(0, 1'b1, 1'b1, 11'h020, 32'h11223344, 4'hF);
    tick();
    a_set(0, 1'b1, 1'b1, 11'h020, 32'hAABBCCDD, 4'h5);
    tick();
    check("a_rdata_hold", a_if.rsp_rdata, 32'hDEADBEEF);
    a_set(0, 1'b1, 1'b1, 11'h020, 32'h00000000, 4'h0);
    #2;
    check("a_zstrb_ready", 32'(a_if.req_ready), 32'h1);
    check("a_zstrb_wstrb", {a_mem_wen, 27'h0, a_mem_wstrb}, 32'h8000_0000);
    tick();
    a_set(0, 1'b1, 1'b0, 11'h023, 32'h0, 4'h0);
    #2;
    check("a_lowbits_addr", 32'(a_mem_addr), 32'h8);
    tick();
    check("a_strb_rsp_valid", 32'(a_if.rsp_valid), 32'h1);
    check("a_strb_rdata", a_if.rsp_rdata, 32'h11BB33DD);

    // Fixed priority under contention
    a_set(0, 1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
    a_set(1, 1'b1, 1'b0, 11'h020, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("a_fix_ready_%0d", c), 32'(a_if.req_ready), 32'h1);
      tick();
      check($sformatf("a_fix_rsp_%0d", c), 32'(a_if.rsp_valid), 32'h1);
      check($sformatf("a_fix_rdata_%0d", c), a_if.rsp_rdata, 32'hDEADBEEF);
    end
    a_set(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    check("a_fix_conflict", a_conflict_cnt, 32'd3);
    #2;
    check("a_p1_ready", 32'(a_if.req_ready), 32'h2);
    tick();
    check("a_p1_rsp", 32'(a_if.rsp_valid), 32'h2);
    check("a_p1_rdata", a_if.rsp_rdata, 32'h11BB33DD);

    // Override on the fixed-priority arbiter
    a_pri_en = 1'b1; a_pri_port = 1'b1;
    a_set(0, 1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
    #2;
    check("a_ovr_ready", 32'(a_if.req_ready), 32'h2);
    tick();
    a_set(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    #2;
    check("a_ovr_idle_ready", 32'(a_if.req_ready), 32'h1);
    tick();
    a_set(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    a_pri_en = 1'b0; a_pri_port = 1'b0;

    // Round-robin: preload one word per port, each port alone
    for (int i = 0; i < 3; i++) begin
      b_set(i, 1'b1, 1'b1, 11'((i + 1) * 4), 32'hB000_0000 + 32'(i), 4'hF);
      #2;
      check($sformatf("b_pre_ready_%0d", i), 32'(b_if.req_ready), 32'(1 << i));
      tick();
      b_set(i, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    end

    // All three ports reading continuously for 6 cycles
    for (int i = 0; i < 3; i++) b_set(i, 1'b1, 1'b0, 11'((i + 1) * 4), 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      #2;
      check($sformatf("b_rr_ready_%0d", c), 32'(b_if.req_ready), 32'(1 << (c % 3)));
      tick();
      check($sformatf("b_rr_rsp_%0d", c), 32'(b_if.rsp_valid), 32'(1 << (c % 3)));
      check($sformatf("b_rr_rdata_%0d", c), b_if.rsp_rdata, 32'hB000_0000 + 32'(c % 3));
    end
    b_set(2, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);

    // Override moves the pointer past the override winner
    b_pri_en = 1'b1; b_pri_port = 2'd1;
    #2;
    check("b_ovr_ready", 32'(b_if.req_ready), 32'h2);
    tick();
    check("b_ovr_rsp", 32'(b_if.rsp_valid), 32'h2);
    b_pri_en = 1'b0;
    b_set(2, 1'b1, 1'b0, 11'h00C, 32'h0, 4'h0);
    #2;
    check("b_ovr_ptr2_ready", 32'(b_if.req_ready), 32'h4);
    tick();
    b_pri_en = 1'b1;
    b_set(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    b_set(2, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    #2;
    check("b_ovr_idle_ready", 32'(b_if.req_ready), 32'h1);
    tick();
    b_pri_en = 1'b0; b_pri_port = 2'd0;
    b_set(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);

    // Reset right after a read accept
    b_set(1, 1'b1, 1'b0, 11'h008, 32'h0, 4'h0);
    b_set(2, 1'b1, 1'b0, 11'h00C, 32'h0, 4'h0);
    #2;
    check("b_pre_rst_ready", 32'(b_if.req_ready), 32'h2);
    tick();
    check("b_pre_rst_rsp", 32'(b_if.rsp_valid), 32'h2);
    check("b_pre_rst_rdata", b_if.rsp_rdata, 32'hB000_0001);
    check("b_pre_rst_conflict", b_conflict_cnt, 32'd9);
    rst_n = 1'b0;
    #1;
    check("b_rst_rsp_valid", 32'(b_if.rsp_valid), 32'h0);
    check("b_rst_rdata", b_if.rsp_rdata, 32'h0);
    check("b_rst_conflict", b_conflict_cnt, 32'h0);
    rst_n = 1'b1;
    #1;
    check("b_post_rst_ready", 32'(b_if.req_ready), 32'h2);
    tick();
    check("b_post_rst_rsp", 32'(b_if.rsp_valid), 32'h2);
    b_set(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    b_set(2, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised, registered arbiter that shares one ideal-memory port among `NUM_PORTS` requesters (MIPS core data port, AXI Lite host, later DMA). It replaces the fixed two-way mask arbitration at the CPU top level, which returned 0xFFFFFFFF on contention. Losing requesters are now stalled through a valid/ready handshake. It adds byte-strobe writes, fixed or round-robin policy, a priority override, registered read responses and a saturating contention counter. It sits between the requesters and the ideal memory's second read port and write port.

## Interface
- `NUM_PORTS`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 11: byte address width; memory word address is `ADDR_WIDTH-2` bits, ≤13.
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pri_en` input 1: priority override enable.
- `pri_port` input $clog2(NUM_PORTS): port that wins whenever `pri_en`=1 and it is valid.
- `req_valid` input NUM_PORTS: per-port request.
- `req_ready` output NUM_PORTS: per-port grant; combinational, one-hot or zero.
- `req_wen` input NUM_PORTS: 1 = write, 0 = read.
- `req_addr` input NUM_PORTS*ADDR_WIDTH: byte addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` input NUM_PORTS*32: write data.
- `req_wstrb` input NUM_PORTS*4: byte enables.
- `rsp_valid` output NUM_PORTS: one-cycle read-response pulse per port.
- `rsp_rdata` output 32: registered read data, shared by all ports.
- `mem_addr` output ADDR_WIDTH-2: word address to memory.
- `mem_wen` output 1: memory write enable.
- `mem_wstrb` output 4: memory byte enables.
- `mem_wdata` output 32: memory write data.
- `mem_ren` output 1: memory read enable.
- `mem_rdata` input 32: combinational read data from memory.
- `conflict_cnt` output 32: saturating count of contention cycles.

## Operation
- Winner selection, in order:
  - If `pri_en`=1 and `req_valid[pri_port]`=1, `pri_port` wins.
  - Else with ARB_MODE 0, the lowest valid index wins.
  - Else with ARB_MODE 1, the first valid index at or after `rr_ptr` wins, searching cyclically.
- Grant: `req_ready[w]`=1 only for the winner. A transfer occurs on `req_valid[w] & req_ready[w]`.
- Memory drive:
  - Drive `mem_addr = req_addr[w][ADDR_WIDTH-1:2]`; `addr[1:0]` is ignored.
  - Write: `mem_wen`=1, `mem_wstrb`/`mem_wdata` from the winner. A write with `wstrb`=0 is granted but leaves memory unchanged.
  - Read: `mem_ren`=1.
  - With no winner, all `mem_*` outputs are 0.
- Read response: `rsp_rdata <= mem_rdata` and `rsp_valid[w] <= 1` on the accept edge. `rsp_rdata` then holds until the next read accept.
- `rr_ptr`:
  - Advances to (w+1) mod NUM_PORTS on every transfer, including override grants.
  - Holds when there is no transfer.
  - Has no effect in ARB_MODE 0.
- `conflict_cnt`: increments each cycle where two or more `req_valid` bits are set. Saturates at 0xFFFFFFFF.
- A requester must hold valid, address and data stable until ready. Dropping valid early is legal and simply loses the slot.

## Timing
- Grant is combinational, 0 cycles. One transfer per cycle maximum; a different port may be granted every cycle.
- Write latency: memory updated at the accept edge.
- Read latency: `rsp_valid` and `rsp_rdata` are valid exactly 1 cycle after accept. Back-to-back reads give back-to-back responses.
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rr_ptr`=0, `conflict_cnt`=0. Combinational outputs are 0 while all `req_valid`=0.
- Reset asserted mid-operation clears any pending `rsp_valid` immediately (asynchronously); that response is lost. The first grant after deassertion uses `rr_ptr`=0.
- If `pri_port` is not valid while `pri_en`=1, normal policy applies in the same cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.

## Test plan
- Single port: port0 writes 0xDEADBEEF at 0x10 with strobe 0xF, then reads 0x10. Required: `rsp_valid[0]` the next cycle with `rsp_rdata`=0xDEADBEEF, and `conflict_cnt`=0.
- Byte strobe: word 0x20 holds 0x11223344; write 0xAABBCCDD with strobe 0b0101. Required: readback 0x11BB33DD.
- Fixed priority (ARB_MODE 0): ports 0 and 1 both hold reads for 3 cycles. Required: port0 granted all 3 cycles, port1 ready=0 throughout, `conflict_cnt`=3.
- Round-robin (ARB_MODE 1, NUM_PORTS 3): all three ports valid continuously for 6 cycles. Required: grant order 0,1,2,0,1,2, and each `rsp_valid` pulse lands one cycle after its grant.
- Override: `pri_en`=1, `pri_port`=1, ports 0 and 1 valid. Required: port1 granted and `rr_ptr` becomes 2. With `pri_en`=1 but port1 idle, port0 is granted.
- Reset: assert `rst_n`=0 in the cycle after a read accept. Required: `rsp_valid` drops immediately, `rsp_rdata`=0, `conflict_cnt`=0, and the first post-reset round-robin grant goes to the lowest valid index.
